// File: rtl/audio_pkg.sv
// Shared audio types for the I2S transmit path: sample/frame widths and the
// signed stereo sample pair that travels from the volume stage to the serializer.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W   = 16;
    localparam int AUDIO_FRAME_BITS = 32;
    localparam int AUDIO_BIT_CNT_W  = $clog2(AUDIO_FRAME_BITS);

    typedef struct packed {
        logic signed [AUDIO_SAMPLE_W-1:0] left;
        logic signed [AUDIO_SAMPLE_W-1:0] right;
    } audio_pair_t;

    // Left word occupies the upper half so it is shifted out first.
    function automatic logic [AUDIO_FRAME_BITS-1:0] pair_to_frame(input audio_pair_t pair);
        return {pair.left, pair.right};
    endfunction

endpackage

// File: rtl/audio_i2s_clkgen.sv
// Bit-clock generator: divides clk by 2*HALF_DIV to make BCLK and emits a
// one-clk strobe in the cycle whose edge drives BCLK from 1 to 0.
module audio_i2s_clkgen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk_o,
    output logic fall_stb_o
);

    localparam int CW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic          bclk_q;
    logic          bclk_d;
    logic          term_cnt;

    assign term_cnt = (div_q == CW'(HALF_DIV - 1));

    always_comb begin
        div_d  = div_q + CW'(1);
        bclk_d = bclk_q;
        if (term_cnt) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign fall_stb_o = term_cnt & bclk_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter with a one-pair holding register and underrun repeat.
// Define AUDIO_I2S_TX_LJ_EN for left-justified output instead of standard I2S.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic signed [AUDIO_SAMPLE_W-1:0] audio_left_in,
    input  logic signed [AUDIO_SAMPLE_W-1:0] audio_right_in,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    output logic                             i2s_bclk,
    output logic                             i2s_lrck,
    output logic                             i2s_data,
    output logic                             underrun
);

    logic                          fall_stb;
    logic                          load_stb;
    logic                          accept;

    logic [AUDIO_BIT_CNT_W-1:0]    bit_cnt_q;
    logic [AUDIO_BIT_CNT_W-1:0]    bit_cnt_d;
    logic [AUDIO_FRAME_BITS-1:0]   shift_q;
    logic [AUDIO_FRAME_BITS-1:0]   shift_d;
    audio_pair_t                   hold_q;
    audio_pair_t                   hold_d;
    audio_pair_t                   last_q;
    audio_pair_t                   last_d;
    logic                          hold_full_q;
    logic                          hold_full_d;
    logic                          underrun_q;
    logic                          underrun_d;
    logic                          start_q;

    audio_i2s_clkgen #(
        .HALF_DIV   (BCLK_HALF_DIV)
    ) u_clkgen (
        .clk        (clk),
        .reset_n    (reset_n),
        .bclk_o     (i2s_bclk),
        .fall_stb_o (fall_stb)
    );

    assign load_stb     = fall_stb & (bit_cnt_q == '1);
    assign accept       = sample_valid & ~hold_full_q;
    assign sample_ready = ~hold_full_q;
    assign i2s_lrck     = bit_cnt_q[AUDIO_BIT_CNT_W-1];
    assign underrun     = underrun_q;

    // The frame already in flight when reset releases never carried a sample,
    // so it is reported as an underrun through start_q.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        last_d      = last_q;
        hold_full_d = hold_full_q;
        underrun_d  = start_q;

        if (fall_stb) begin
            bit_cnt_d = bit_cnt_q + AUDIO_BIT_CNT_W'(1);
            shift_d   = {shift_q[AUDIO_FRAME_BITS-2:0], 1'b0};
        end

        if (load_stb) begin
            if (hold_full_q) begin
                shift_d     = pair_to_frame(hold_q);
                last_d      = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = pair_to_frame(last_q);
                underrun_d = 1'b1;
            end
        end

        // Only reachable with the holding register empty, so never collides with a load.
        if (accept) begin
            hold_d.left  = audio_left_in;
            hold_d.right = audio_right_in;
            hold_full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            start_q     <= 1'b0;
        end
    end

`ifdef AUDIO_I2S_TX_LJ_EN
    assign i2s_data = shift_q[AUDIO_FRAME_BITS-1];
`else
    // One-BCLK delay so the left MSB lands one bit after the word-select edge.
    logic data_q;
    logic data_d;

    always_comb begin
        data_d = data_q;
        if (fall_stb) begin
            data_d = shift_q[AUDIO_FRAME_BITS-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 1'b0;
        end else begin
            data_q <= data_d;
        end
    end

    assign i2s_data = data_q;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: decodes serial frames at every BCLK rise
// and compares them with hand-computed sample pairs (honours AUDIO_I2S_TX_LJ_EN).
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] audio_left_in = 16'h0000;
    logic [15:0] audio_right_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        underrun;

    int checks = 0;
    int errors = 0;

`ifdef AUDIO_I2S_TX_LJ_EN
    localparam int DATA_OFS = 0;
`else
    localparam int DATA_OFS = 1;
`endif

    audio_i2s_tx #(
        .BCLK_HALF_DIV  (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .audio_left_in  (audio_left_in),
        .audio_right_in (audio_right_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrck       (i2s_lrck),
        .i2s_data       (i2s_data),
        .underrun       (underrun)
    );

    initial forever #5 clk = ~clk;

    // Free-running observers, sampled on the inactive clock edge.
    int   cyc = 0;
    int   last_bclk_rise = 0;
    int   bclk_per = 0;
    int   last_lr_fall = 0;
    int   lr_per = 0;
    int   ur_hi = 0;
    int   ur_edges = 0;
    int   acc_cnt = 0;
    int   stab_viol = 0;
    logic m_bclk_prev = 1'b0;
    logic m_lr_prev = 1'b0;
    logic m_ur_prev = 1'b0;
    logic m_data_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (i2s_bclk && !m_bclk_prev) begin
            bclk_per       <= cyc - last_bclk_rise;
            last_bclk_rise <= cyc;
        end
        if (!i2s_lrck && m_lr_prev) begin
            lr_per       <= cyc - last_lr_fall;
            last_lr_fall <= cyc;
        end
        if (i2s_bclk && m_bclk_prev && (i2s_data !== m_data_prev || i2s_lrck !== m_lr_prev))
            stab_viol <= stab_viol + 1;
        if (underrun)
            ur_hi <= ur_hi + 1;
        if (underrun && !m_ur_prev)
            ur_edges <= ur_edges + 1;
        if (sample_valid && sample_ready)
            acc_cnt <= acc_cnt + 1;
        m_bclk_prev <= i2s_bclk;
        m_lr_prev   <= i2s_lrck;
        m_ur_prev   <= underrun;
        m_data_prev <= i2s_data;
    end

    logic cur_data;
    logic cur_lrck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the next BCLK rise, holding the bits seen there.
    task automatic next_rise();
        logic prev;
        logic found;
        int   n;
        @(negedge clk);
        prev  = i2s_bclk;
        found = 1'b0;
        n     = 0;
        while (!found && n < 64) begin
            @(negedge clk);
            n++;
            found = (prev === 1'b0 && i2s_bclk === 1'b1);
            prev  = i2s_bclk;
        end
        if (!found) check("bclk_rise_timeout", 32'(found), 32'd1);
        cur_data = i2s_data;
        cur_lrck = i2s_lrck;
    endtask

    // Entered positioned at bit 0 of a frame; leaves positioned at bit 0 of the next.
    task automatic run_frame(input string name, input logic [15:0] exp_l, input logic [15:0] exp_r);
        logic        sd [0:32];
        logic        sl [0:32];
        logic [15:0] got_l;
        logic [15:0] got_r;
        logic        lr_ok;
        sd[0] = cur_data;
        sl[0] = cur_lrck;
        for (int k = 1; k <= 32; k++) begin
            next_rise();
            sd[k] = cur_data;
            sl[k] = cur_lrck;
        end
        lr_ok = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (sl[k] !== ((k % 32) >= 16)) lr_ok = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            got_l[15-k] = sd[DATA_OFS + k];
            got_r[15-k] = sd[DATA_OFS + 16 + k];
        end
        check({name, "_left"}, 32'(got_l), 32'(exp_l));
        check({name, "_right"}, 32'(got_r), 32'(exp_r));
        check({name, "_lrck"}, 32'(lr_ok), 32'd1);
    endtask

    int acc_base;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_bclk", 32'(i2s_bclk), 32'd0);
        check("rst_lrck", 32'(i2s_lrck), 32'd0);
        check("rst_data", 32'(i2s_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);

        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        audio_left_in  = 16'h8001;
        audio_right_in = 16'h7FFE;
        sample_valid   = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
        @(negedge clk);
        check("ready_after_accept", 32'(sample_ready), 32'd0);

        // Frame in flight at reset release is an underrun frame of zeros
        next_rise();
        check("f0_first_lrck", 32'(cur_lrck), 32'd0);
        @(posedge clk); #1;
        // Filled while frame 0 is still shifting is not possible (holding full); supply after it loads
        sample_valid = 1'b0;
        run_frame("f0_zero", 16'h0000, 16'h0000);
        check("f0_underrun_cnt", 32'(ur_edges), 32'd1);

        @(posedge clk); #1;
        audio_left_in  = 16'h1234;
        audio_right_in = 16'hABCD;
        sample_valid   = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
        run_frame("f1_pair", 16'h8001, 16'h7FFE);
        check("f1_underrun_cnt", 32'(ur_edges), 32'd1);

        run_frame("f2_pair", 16'h1234, 16'hABCD);
        check("f3_load_underrun_cnt", 32'(ur_edges), 32'd2);
        run_frame("f3_repeat", 16'h1234, 16'hABCD);
        check("f4_load_underrun_cnt", 32'(ur_edges), 32'd3);

        // Continuous valid; data changes while not ready must be ignored
        acc_base = acc_cnt;
        @(posedge clk); #1;
        audio_left_in  = 16'hC3C3;
        audio_right_in = 16'h3C3C;
        sample_valid   = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_low_midframe", 32'(sample_ready), 32'd0);
        @(posedge clk); #1;
        audio_left_in  = 16'h0001;
        audio_right_in = 16'h8000;
        run_frame("f4_repeat", 16'h1234, 16'hABCD);
        run_frame("f5_first_held", 16'hC3C3, 16'h3C3C);
        run_frame("f6_second_held", 16'h0001, 16'h8000);
        check("accepts_per_frame", 32'(acc_cnt - acc_base), 32'd4);
        check("no_extra_underrun", 32'(ur_edges), 32'd3);
        check("bclk_period", 32'(bclk_per), 32'd8);
        check("lrck_period", 32'(lr_per), 32'd256);
        @(posedge clk); #1 sample_valid = 1'b0;

        // Asynchronous reset at bit 20 of frame 7
        for (int k = 0; k < 20; k++) next_rise();
        check("pre_rst_bclk", 32'(i2s_bclk), 32'd1);
        check("pre_rst_lrck", 32'(i2s_lrck), 32'd1);
        check("pre_rst_ready", 32'(sample_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_bclk", 32'(i2s_bclk), 32'd0);
        check("async_rst_lrck", 32'(i2s_lrck), 32'd0);
        check("async_rst_data", 32'(i2s_data), 32'd0);
        check("async_rst_underrun", 32'(underrun), 32'd0);
        check("async_rst_ready", 32'(sample_ready), 32'd1);
        @(posedge clk);
        @(posedge clk); #1 reset_n = 1'b1;

        next_rise();
        run_frame("r0_zero", 16'h0000, 16'h0000);
        check("r0_underrun_cnt", 32'(ur_edges), 32'd5);
        run_frame("r1_zero", 16'h0000, 16'h0000);
        check("r1_underrun_cnt", 32'(ur_edges), 32'd6);
        check("underrun_width", 32'(ur_hi), 32'(ur_edges));
        check("data_stable_at_rise", 32'(stab_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF_DIV, default 4: clk cycles per BCLK half-period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: the only clock; all flops on rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port audio_left_in, input, 16: signed two's-complement left sample (output of stereo volume stage).
REQ-005 SHALL have port audio_right_in, input, 16: signed right sample.
REQ-006 SHALL have port sample_valid, input, 1: the sample pair is valid this cycle.
REQ-007 SHALL have port sample_ready, output, 1: the holding register is empty and can accept a pair.
REQ-008 SHALL have port i2s_bclk, output, 1: serial bit clock.
REQ-009 SHALL have port i2s_lrck, output, 1: word select; 0 = left, 1 = right.
REQ-010 SHALL have port i2s_data, output, 1: serial data, MSB first.
REQ-011 SHALL have port underrun, output, 1: one-clk pulse when a frame starts with no new sample.

Function
REQ-012 SHALL accept a pair into the holding register on any clk where sample_valid and sample_ready are both 1; sample_ready SHALL be the inverse of holding-full.
REQ-013 SHALL ignore sample_valid while sample_ready is 0; holding contents SHALL remain unchanged.
REQ-014 SHALL run a divider 0..BCLK_HALF_DIV-1 and toggle i2s_bclk at terminal count; sample rate = f_clk / (64*BCLK_HALF_DIV).
REQ-015 SHALL advance a 5-bit bit counter (mod 32) on each i2s_bclk falling-edge event; i2s_lrck = bit_cnt[4].
REQ-016 SHALL load a 32-bit frame {left,right} into the shift register on the falling-edge event that wraps bit_cnt 31->0, and shift left by one on every other falling-edge event.
REQ-017 SHALL, at frame load with holding full, take the holding pair, clear holding-full, and store the pair as last_frame.
REQ-018 SHALL, at frame load with holding empty, reload last_frame and pulse underrun high for exactly one clk.
REQ-019 SHALL NOT accept a new pair in the load cycle itself: sample_ready rises on the clk after the load.
REQ-020 SHALL change i2s_data and i2s_lrck only on bclk falling-edge events, so they are stable at every bclk rising edge.
REQ-021 SHALL, in I2S format, present the MSB of left one BCLK after the i2s_lrck 1->0 transition; a one-bit delay flop drives i2s_data.

Reset
REQ-022 SHALL, while reset_n = 0, force i2s_bclk = 0, i2s_lrck = 0, i2s_data = 0, underrun = 0, sample_ready = 1, with divider, bit_cnt, shift register, holding and last_frame cleared to 0.
REQ-023 SHALL, on reset deassertion mid-frame, restart at bit_cnt = 0 and transmit zero frames until a sample is accepted; the first frame SHALL raise underrun.

Configuration
REQ-024 SHALL use macro AUDIO_I2S_TX_LJ_EN: when defined, output is left-justified (delay flop bypassed, MSB coincident with i2s_lrck transition); when undefined, standard I2S per REQ-021.

Structure
REQ-025 SHALL place AUDIO_SAMPLE_W = 16, AUDIO_FRAME_BITS = 32, and the signed stereo sample-pair typedef in shared package audio_pkg.
REQ-026 SHALL implement divider and bclk/falling-edge strobe generation in sub-module audio_i2s_clkgen.

Verification
REQ-027 SHALL cover: reset then pair L=16'h8001, R=16'h7FFE with BCLK_HALF_DIV=4 -> first frame underrun=1 with zero data; next frame serializes 1000_0000_0000_0001 under lrck=0, then 0111_1111_1111_1110 under lrck=1.
REQ-028 SHALL cover: clock timing -> i2s_bclk period = 8 clk; i2s_lrck period = 256 clk; data stable at every bclk rise.
REQ-029 SHALL cover: sample_valid held high continuously -> exactly one pair accepted per 256 clk, sample_ready low between acceptance and the next load.
REQ-030 SHALL cover: no pair supplied for two frames after L=16'h1234, R=16'hABCD -> 16'h1234/16'hABCD repeated both frames with one underrun pulse each.
REQ-031 SHALL cover: reset_n pulsed low at bit_cnt = 20 -> all outputs take reset values asynchronously; transmission restarts at bit_cnt 0.
REQ-032 SHALL cover: build with AUDIO_I2S_TX_LJ_EN -> left MSB appears on the same bclk fall as i2s_lrck 1->0; without it, one bclk later.
